// File: rtl/ncl_quat_pkg.sv
// rtl/ncl_quat_pkg.sv - shared types and 1-of-4 code classification for the quaternary NCL sink
package ncl_quat_pkg;

    typedef enum logic {
        WAIT_DATA = 1'b0,
        WAIT_NULL = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        CLS_NULL  = 2'd0,
        CLS_LEGAL = 2'd1,
        CLS_MULTI = 2'd2
    } code_cls_e;

    typedef struct packed {
        code_cls_e  cls;
        logic [1:0] idx;
    } code_info_t;

    localparam logic [3:0] NULL_CODE = 4'b0000;

    function automatic code_info_t onehot4(input logic [3:0] word);
        code_info_t r;
        r.cls = CLS_MULTI;
        r.idx = 2'd0;
        case (word)
            NULL_CODE: r.cls = CLS_NULL;
            4'b0001:   begin r.cls = CLS_LEGAL; r.idx = 2'd0; end
            4'b0010:   begin r.cls = CLS_LEGAL; r.idx = 2'd1; end
            4'b0100:   begin r.cls = CLS_LEGAL; r.idx = 2'd2; end
            4'b1000:   begin r.cls = CLS_LEGAL; r.idx = 2'd3; end
            default:   r.cls = CLS_MULTI;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ncl_quat_sync_sink_if.sv
// rtl/ncl_quat_sync_sink_if.sv - quaternary rails, acknowledge and status bundle
interface ncl_quat_sync_sink_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       quat_in;
    logic             err_clr;
    logic             quat_ack;
    logic [1:0]       value;
    logic             value_valid;
    logic [CNT_W-1:0] token_count;
    logic             err_multi;
    logic             err_timeout;

    modport master (
        output quat_in, err_clr,
        input  quat_ack, value, value_valid, token_count, err_multi, err_timeout
    );

    modport slave (
        input  quat_in, err_clr,
        output quat_ack, value, value_valid, token_count, err_multi, err_timeout
    );
endinterface

// File: rtl/ncl_rail_sync.sv
// rtl/ncl_rail_sync.sv - multi-stage rail synchroniser with asynchronous clear
module ncl_rail_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             init,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] next_word,
    output logic [WIDTH-1:0] sync_word
);
    logic [WIDTH-1:0] chain_q [STAGES];
    logic [WIDTH-1:0] chain_d [STAGES];

    always_comb begin
        chain_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            chain_d[i] = chain_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            for (int i = 0; i < STAGES; i++) begin
                chain_q[i] <= '0;
            end
        end else begin
            chain_q <= chain_d;
        end
    end

    // next_word is what the last stage will hold after this edge; the sink uses it for change detection
    assign next_word = chain_q[STAGES-2];
    assign sync_word = chain_q[STAGES-1];
endmodule

// File: rtl/ncl_quat_sync_sink.sv
// rtl/ncl_quat_sync_sink.sv - clocked 1-of-4 NCL consumer: sync, settle, decode, acknowledge
module ncl_quat_sync_sink
    import ncl_quat_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE      = 2,
    parameter int TIMEOUT     = 64,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 init,
    ncl_quat_sync_sink_if.slave  bus
);
    localparam int SC_W = $clog2(SETTLE + 1);
    localparam int WC_W = $clog2(TIMEOUT + 1);

    logic [3:0]       next_word, sync_word;
    state_e           state_q, state_d;
    logic [SC_W-1:0]  stable_cnt_q, stable_cnt_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [1:0]       value_q, value_d;
    logic             value_valid_q, value_valid_d;
    logic [CNT_W-1:0] token_count_q, token_count_d;
    logic             err_multi_q, err_multi_d;
    logic             err_timeout_q, err_timeout_d;
    logic             quat_ack_q, quat_ack_d;
    logic             is_stable, timeout_hit;
    code_info_t       info;

    ncl_rail_sync #(.WIDTH(4), .STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .init      (init),
        .d         (bus.quat_in),
        .next_word (next_word),
        .sync_word (sync_word)
    );

    always_comb begin
        stable_cnt_d = '0;
        if (next_word == sync_word) begin
            stable_cnt_d = (stable_cnt_q == SC_W'(SETTLE)) ? stable_cnt_q : stable_cnt_q + 1'b1;
        end
        is_stable = (stable_cnt_q >= SC_W'(SETTLE - 1));
        info      = onehot4(sync_word);
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state_q       <= WAIT_DATA;
            stable_cnt_q  <= '0;
            wait_cnt_q    <= '0;
            value_q       <= '0;
            value_valid_q <= 1'b0;
            token_count_q <= '0;
            err_multi_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            quat_ack_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            stable_cnt_q  <= stable_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            value_q       <= value_d;
            value_valid_q <= value_valid_d;
            token_count_q <= token_count_d;
            err_multi_q   <= err_multi_d;
            err_timeout_q <= err_timeout_d;
            quat_ack_q    <= quat_ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_DATA: if (is_stable && info.cls != CLS_NULL) state_d = WAIT_NULL;
            WAIT_NULL: if (is_stable && info.cls == CLS_NULL) state_d = WAIT_DATA;
            default:   state_d = WAIT_DATA;
        endcase
    end

    always_comb begin
        value_d       = value_q;
        value_valid_d = 1'b0;
        token_count_d = token_count_q;
        quat_ack_d    = (state_d == WAIT_NULL);
        timeout_hit   = 1'b0;
        wait_cnt_d    = '0;
        if (state_d == state_q) begin
            wait_cnt_d  = (wait_cnt_q == WC_W'(TIMEOUT)) ? wait_cnt_q : wait_cnt_q + 1'b1;
            timeout_hit = (wait_cnt_q == WC_W'(TIMEOUT - 1));
        end
        if (state_q == WAIT_DATA && is_stable && info.cls == CLS_LEGAL) begin
            value_d       = info.idx;
            value_valid_d = 1'b1;
            token_count_d = token_count_q + 1'b1;
        end
        // a set condition on the same edge as err_clr must win
        err_multi_d = err_multi_q && !bus.err_clr;
        if (state_q == WAIT_DATA && is_stable && info.cls == CLS_MULTI) begin
            err_multi_d = 1'b1;
        end
        err_timeout_d = timeout_hit || (err_timeout_q && !bus.err_clr);
    end

    assign bus.quat_ack    = quat_ack_q;
    assign bus.value       = value_q;
    assign bus.value_valid = value_valid_q;
    assign bus.token_count = token_count_q;
    assign bus.err_multi   = err_multi_q;
    assign bus.err_timeout = err_timeout_q;
endmodule

// File: tb/tb_ncl_quat_sync_sink.sv
// tb/tb_ncl_quat_sync_sink.sv - directed self-checking bench for ncl_quat_sync_sink
module tb_ncl_quat_sync_sink;
    logic clk = 1'b0;
    logic init = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   ack_rise = 0;
    int   ack_fall = 0;

    ncl_quat_sync_sink_if #(.CNT_W(16)) bus ();

    ncl_quat_sync_sink #(
        .SYNC_STAGES (2),
        .SETTLE      (2),
        .TIMEOUT     (64),
        .CNT_W       (16)
    ) dut (
        .clk  (clk),
        .init (init),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, bus.quat_ack, 0);
        check({tag, "_value"}, bus.value, 0);
        check({tag, "_vv"}, bus.value_valid, 0);
        check({tag, "_count"}, bus.token_count, 0);
        check({tag, "_emulti"}, bus.err_multi, 0);
        check({tag, "_etime"}, bus.err_timeout, 0);
    endtask

    task automatic run_token(input logic [3:0] code, input logic [1:0] exp_val, input logic [15:0] exp_cnt);
        int n;
        bus.quat_in = code;
        n = 0;
        while (!bus.quat_ack && n < 20) begin
            tick(1);
            n++;
        end
        ack_rise += bus.quat_ack ? 1 : 0;
        check("data_latency", n, 4);
        check("value", bus.value, exp_val);
        check("vv_high", bus.value_valid, 1);
        check("token_count", bus.token_count, exp_cnt);
        tick(1);
        check("vv_single", bus.value_valid, 0);
        tick(2);
        bus.quat_in = 4'b0000;
        n = 0;
        while (bus.quat_ack && n < 20) begin
            tick(1);
            n++;
        end
        ack_fall += bus.quat_ack ? 0 : 1;
        check("null_latency", n, 4);
        tick(2);
    endtask

    initial begin
        int vv_seen;
        bus.quat_in = 4'b0100;
        bus.err_clr = 1'b0;

        // reset held with DATA on the rails
        tick(5);
        check_all_zero("reset");
        init = 1'b0;
        run_token(4'b0100, 2'd2, 16'd1);

        // full token sequence from a fresh reset
        init = 1'b1;
        tick(1);
        check_all_zero("reset2");
        init = 1'b0;
        ack_rise = 0;
        ack_fall = 0;
        run_token(4'b0001, 2'd0, 16'd1);
        run_token(4'b0010, 2'd1, 16'd2);
        run_token(4'b0100, 2'd2, 16'd3);
        run_token(4'b1000, 2'd3, 16'd4);
        check("ack_rises", ack_rise, 4);
        check("ack_falls", ack_fall, 4);
        check("seq_emulti", bus.err_multi, 0);
        check("seq_etime", bus.err_timeout, 0);

        // one-cycle glitch is ignored
        vv_seen = 0;
        bus.quat_in = 4'b0001;
        tick(1);
        bus.quat_in = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            if (bus.value_valid || bus.quat_ack) vv_seen++;
            tick(1);
        end
        check("glitch_seen", vv_seen, 0);
        check("glitch_count", bus.token_count, 4);

        // stable multi-rail code
        bus.quat_in = 4'b0101;
        tick(3);
        check("multi_pre_ack", bus.quat_ack, 0);
        tick(1);
        check("multi_err", bus.err_multi, 1);
        check("multi_ack", bus.quat_ack, 1);
        check("multi_vv", bus.value_valid, 0);
        check("multi_count", bus.token_count, 4);
        check("multi_value", bus.value, 3);
        tick(2);
        bus.quat_in = 4'b0000;
        tick(4);
        check("multi_null_ack", bus.quat_ack, 0);
        check("multi_sticky", bus.err_multi, 1);
        bus.err_clr = 1'b1;
        tick(1);
        bus.err_clr = 1'b0;
        check("multi_clr", bus.err_multi, 0);

        // wait in WAIT_NULL exceeds the timeout
        bus.quat_in = 4'b1000;
        tick(4);
        check("to_ack", bus.quat_ack, 1);
        check("to_count", bus.token_count, 5);
        tick(63);
        check("to_early", bus.err_timeout, 0);
        tick(1);
        check("to_set", bus.err_timeout, 1);
        tick(12);
        check("to_ack_hold", bus.quat_ack, 1);
        bus.quat_in = 4'b0000;
        tick(4);
        check("to_null_ack", bus.quat_ack, 0);
        check("to_sticky", bus.err_timeout, 1);

        // asynchronous reset while acknowledging
        bus.quat_in = 4'b0010;
        tick(4);
        check("mid_ack_pre", bus.quat_ack, 1);
        #2;
        init = 1'b1;
        #1;
        check("mid_ack_drop", bus.quat_ack, 0);
        check("mid_count", bus.token_count, 0);
        check("mid_etime", bus.err_timeout, 0);
        bus.quat_in = 4'b0000;
        tick(2);
        init = 1'b0;
        vv_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (bus.value_valid || bus.quat_ack) vv_seen++;
        end
        check("post_reset_idle", vv_seen, 0);
        check("post_reset_count", bus.token_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
